// File: rtl/nibble_serial_sub_pkg.sv
// ----------------------------------------------------------------------------
// | nibble_serial_sub_pkg : shared FSM encoding and slice width               |
// | Rev 1.0                                                                   |
// ----------------------------------------------------------------------------
`default_nettype none

package nibble_serial_sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sub4_bla.sv
// ----------------------------------------------------------------------------
// | sub4_bla : combinational 4-bit borrow-lookahead subtract slice            |
// | Rev 1.0                                                                   |
// ----------------------------------------------------------------------------
`default_nettype none

module sub4_bla
  import nibble_serial_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               bi,
  output logic [SLICE_W-1:0] d,
  output logic               bo
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_bw;
  logic               w_grp_g;
  logic               w_grp_p;

  assign w_g = ~x & y;
  assign w_p = ~(x ^ y);

  // Every internal borrow is a flat sum of products of g/p and bi: no ripple.
  assign w_bw[0] = bi;
  assign w_bw[1] = w_g[0] | (w_p[0] & bi);
  assign w_bw[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bi);
  assign w_bw[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & bi);

  assign w_grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign w_grp_p = &w_p;

  assign bo = w_grp_g | (w_grp_p & bi);
  assign d  = x ^ y ^ w_bw;

endmodule

`default_nettype wire

// File: rtl/nibble_serial_sub.sv
// ----------------------------------------------------------------------------
// | nibble_serial_sub : WIDTH-bit A-B-BIN, one 4-bit slice per clock, LSB 1st |
// | Rev 1.0                                                                   |
// ----------------------------------------------------------------------------
`default_nettype none

module nibble_serial_sub
  import nibble_serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int                 NIB    = WIDTH / SLICE_W;
  localparam int                 IDX_W  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0]   C_LAST = IDX_W'(NIB - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_bw;
  logic [IDX_W-1:0]   r_idx;

  logic [SLICE_W-1:0] w_x;
  logic [SLICE_W-1:0] w_y;
  logic [SLICE_W-1:0] w_d;
  logic               w_bo;

  assign w_x = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_y = r_b[r_idx*SLICE_W +: SLICE_W];

  sub4_bla u_slice (
    .x  (w_x),
    .y  (w_y),
    .bi (r_bw),
    .d  (w_d),
    .bo (w_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_bw    <= 1'b0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_bw    <= bin;
            r_idx   <= '0;
            diff    <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          diff[r_idx*SLICE_W +: SLICE_W] <= w_d;
          r_bw  <= w_bo;
          r_idx <= r_idx + 1'b1;
          if (r_idx == C_LAST) begin
            // Last slice is the top nibble, so flags use w_d for the MSB part.
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            bout    <= w_bo;
            ovf     <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d[SLICE_W-1] ^ r_a[WIDTH-1]);
            zero    <= (diff[WIDTH-SLICE_W-1:0] == '0) && (w_d == '0);
            r_state <= ST_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_sub.sv
// ----------------------------------------------------------------------------
// | tb_nibble_serial_sub : directed + random check against arithmetic model   |
// | Rev 1.0                                                                   |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nibble_serial_sub;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_bout, prev_ovf, prev_zero;

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                       output logic [15:0] md, output logic mbo, output logic mov,
                       output logic mz);
    int u;
    int s;
    u   = int'(ma) - int'(mb) - int'(mbin);
    s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    md  = u[15:0];
    mbo = (u < 0);
    mov = (s > 32767) || (s < -32768);
    mz  = (md == 16'h0000);
  endtask

  // Entered at the first negedge after the accepting edge.
  task automatic wait_result(input logic [15:0] ea, input logic [15:0] eb, input logic ebin,
                             input bit inject);
    int         cyc;
    logic [15:0] md;
    logic        mbo, mov, mz;
    check("busy_on_accept", busy, 1);
    check("diff_cleared", diff, 0);
    check("bout_held", bout, prev_bout);
    check("ovf_held", ovf, prev_ovf);
    check("zero_held", zero, prev_zero);
    cyc = 1;
    while (done !== 1'b1 && cyc < 12) begin
      if (inject && cyc == 1) begin
        a = 16'hFFFF; b = 16'($urandom); bin = 1'b1; start = 1'b1;
      end else if (inject && cyc == 2) begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, NIB + 1);
    check("busy_at_done", busy, 0);
    model(ea, eb, ebin, md, mbo, mov, mz);
    check("diff", diff, md);
    check("bout", bout, mbo);
    check("ovf", ovf, mov);
    check("zero", zero, mz);
    prev_bout = mbo;
    prev_ovf  = mov;
    prev_zero = mz;
  endtask

  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic obin,
                        input bit inject);
    @(negedge clk);
    a = oa; b = ob; bin = obin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    wait_result(oa, ob, obin, inject);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("bout_hold_idle", bout, prev_bout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] n2a, n2b;
    logic        n2bin;
    int          done_seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    prev_bout = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);

    run_op(16'h0005, 16'h0003, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0010, 16'h0000, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);

    // Back-to-back: start held high through DONE.
    n2a = 16'hA5A5; n2b = 16'h5A5B; n2bin = 1'b1;
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = n2a; b = n2b; bin = n2bin;
    wait_result(16'h1234, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    wait_result(n2a, n2b, n2bin, 1'b0);
    @(negedge clk);
    check("b2b_done_drop", done, 0);

    // Reset in the second RUN cycle after a result with bout=1.
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    check("abort_ovf", ovf, 0);
    check("abort_zero", zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_bout = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    for (int i = 0; i < 25; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), (i % 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
